// File: rtl/cpu_boot_pkg.sv
// rtl/cpu_boot_pkg.sv - shared state encoding, strides and depths for the CPU boot sequencer
package cpu_boot_pkg;

  localparam int IMEM_WORDS_DEF = 512;
  localparam int DMEM_WORDS_DEF = 1024;
  localparam int IMEM_STRIDE    = 4;
  localparam int DMEM_STRIDE    = 8;
  localparam int IDX_W          = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_I,
    ST_LOAD_D,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_WAIT,
    ST_DUMP_HOLD,
    ST_DONE
  } state_t;

  // Earliest remaining phase that has work to do; empty jobs fall through to DONE.
  function automatic state_t first_phase(input logic has_i, input logic has_d,
                                         input logic has_r, input logic has_u);
    if (has_i) return ST_LOAD_I;
    if (has_d) return ST_LOAD_D;
    if (has_r) return ST_RUN;
    if (has_u) return ST_DUMP_RD;
    return ST_DONE;
  endfunction

endpackage

// File: rtl/boot_word_counter.sv
// rtl/boot_word_counter.sv - clearable up-counter with terminal-count flag
module boot_word_counter #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Clear wins over increment so a phase can restart on the cycle it is entered.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// rtl/cpu_boot_ctrl.sv - load/run/dump sequencer owning the CPU memories, enable and reset
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [9:0]       imem_len,
  input  logic [10:0]      dmem_len,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [10:0]      dump_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic             cpu_enable,
  output logic             cpu_arst_n,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
);

  localparam logic [IDX_W-1:0] IMEM_MAX = IDX_W'(IMEM_WORDS);
  localparam logic [IDX_W-1:0] DMEM_MAX = IDX_W'(DMEM_WORDS);

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_imem_len, r_dmem_len, r_dump_len;
  logic [CNT_W-1:0]   r_run_cycles;
  logic               r_released;
  logic [63:0]        r_out_data;

  logic [IDX_W-1:0]   w_imem_cl, w_dmem_cl, w_dump_cl;
  logic               w_start_ok;
  logic [IDX_W-1:0]   w_idx, w_idx_term;
  logic               w_idx_tc, w_idx_clr, w_idx_inc;
  logic [CNT_W-1:0]   w_run_cnt_unused;
  logic               w_run_tc;
  logic               w_in_dump;

  assign w_imem_cl  = ({1'b0, imem_len} > IMEM_MAX) ? IMEM_MAX : {1'b0, imem_len};
  assign w_dmem_cl  = (dmem_len > DMEM_MAX) ? DMEM_MAX : dmem_len;
  assign w_dump_cl  = (dump_len > DMEM_MAX) ? DMEM_MAX : dump_len;
  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_in_dump  = (r_state == ST_DUMP_RD) || (r_state == ST_DUMP_WAIT) ||
                      (r_state == ST_DUMP_HOLD);

  // One shared index: restart on entering a new phase, but keep it across the dump loop.
  assign w_idx_clr  = (w_state_next != r_state) && !w_in_dump;
  assign w_idx_term = (r_state == ST_LOAD_I) ? r_imem_len - 11'd1 :
                      (r_state == ST_LOAD_D) ? r_dmem_len - 11'd1 :
                                               r_dump_len - 11'd1;

  boot_word_counter #(.W(IDX_W)) u_idx_cnt (
    .i_clk  (clk),
    .i_arst (arst),
    .i_clr  (w_idx_clr),
    .i_inc  (w_idx_inc),
    .i_term (w_idx_term),
    .o_cnt  (w_idx),
    .o_tc   (w_idx_tc)
  );

  // The run phase only needs the terminal flag, not the count itself.
  boot_word_counter #(.W(CNT_W)) u_run_cnt (
    .i_clk  (clk),
    .i_arst (arst),
    .i_clr  (r_state != ST_RUN),
    .i_inc  (r_state == ST_RUN),
    .i_term (r_run_cycles - CNT_W'(1)),
    .o_cnt  (w_run_cnt_unused),
    .o_tc   (w_run_tc)
  );

  // State register, job parameters, CPU-release flag and readback holding register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= ST_IDLE;
      r_imem_len   <= '0;
      r_dmem_len   <= '0;
      r_dump_len   <= '0;
      r_run_cycles <= '0;
      r_released   <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_imem_len   <= w_imem_cl;
        r_dmem_len   <= w_dmem_cl;
        r_dump_len   <= w_dump_cl;
        r_run_cycles <= run_cycles;
        r_released   <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_released <= 1'b1;
      end
      if (r_state == ST_DUMP_WAIT) begin
        r_out_data <= rdata_ext_2;
      end
    end
  end

  // Next state and per-state memory/stream strobes.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    cpu_enable   = 1'b0;
    wen_ext      = 1'b0;
    addr_ext     = '0;
    wdata_ext    = '0;
    wen_ext_2    = 1'b0;
    ren_ext_2    = 1'b0;
    addr_ext_2   = '0;
    wdata_ext_2  = '0;
    w_idx_inc    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_next = first_phase(w_imem_cl != '0, w_dmem_cl != '0,
                                     run_cycles != '0, w_dump_cl != '0);
        end
      end
      ST_LOAD_I: begin
        in_ready = 1'b1;
        addr_ext = 64'(w_idx) * 64'(IMEM_STRIDE);
        if (in_valid) begin
          wen_ext   = 1'b1;
          wdata_ext = in_data[31:0];
          w_idx_inc = 1'b1;
          if (w_idx_tc) begin
            w_state_next = first_phase(1'b0, r_dmem_len != '0,
                                       r_run_cycles != '0, r_dump_len != '0);
          end
        end
      end
      ST_LOAD_D: begin
        in_ready   = 1'b1;
        addr_ext_2 = 64'(w_idx) * 64'(DMEM_STRIDE);
        if (in_valid) begin
          wen_ext_2   = 1'b1;
          wdata_ext_2 = in_data;
          w_idx_inc   = 1'b1;
          if (w_idx_tc) begin
            w_state_next = first_phase(1'b0, 1'b0, r_run_cycles != '0, r_dump_len != '0);
          end
        end
      end
      ST_RUN: begin
        cpu_enable = 1'b1;
        if (w_run_tc) begin
          w_state_next = (r_dump_len != '0) ? ST_DUMP_RD : ST_DONE;
        end
      end
      ST_DUMP_RD: begin
        ren_ext_2    = 1'b1;
        addr_ext_2   = 64'(w_idx) * 64'(DMEM_STRIDE);
        w_state_next = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        w_state_next = ST_DUMP_HOLD;
      end
      ST_DUMP_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_idx_inc    = 1'b1;
          w_state_next = w_idx_tc ? ST_DONE : ST_DUMP_RD;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign ren_ext    = 1'b0;
  assign out_data   = r_out_data;
  assign done       = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign cpu_arst_n = (r_state == ST_RUN) || r_released;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb/tb_cpu_boot_ctrl.sv - randomized self-checking bench for cpu_boot_ctrl
module tb_cpu_boot_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             arst;
  logic             start;
  logic [9:0]       imem_len;
  logic [10:0]      dmem_len;
  logic [CNT_W-1:0] run_cycles;
  logic [10:0]      dump_len;
  logic             in_valid, in_ready;
  logic [63:0]      in_data;
  logic             out_valid, out_ready;
  logic [63:0]      out_data;
  logic             busy, done, cpu_enable, cpu_arst_n;
  logic [63:0]      addr_ext, addr_ext_2;
  logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]      wdata_ext;
  logic [63:0]      wdata_ext_2, rdata_ext_2;

  always #5 clk = ~clk;

  cpu_boot_ctrl #(.IMEM_WORDS(512), .DMEM_WORDS(1024), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles), .dump_len(dump_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cpu_enable(cpu_enable), .cpu_arst_n(cpu_arst_n),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seed_word(input int i);
    return {32'(i) * 32'h9E37_79B9, 32'hC0DE_0000 | 32'(i)};
  endfunction

  // Data SRAM with one-cycle read latency; the reference copy lives in ref_d.
  logic        mem_init;
  logic [63:0] sram_d [0:1023];
  logic [63:0] ref_d  [0:1023];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) sram_d[i] <= seed_word(i);
    end else begin
      if (wen_ext_2) sram_d[addr_ext_2[12:3]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= sram_d[addr_ext_2[12:3]];
    end
  end

  // Passive monitor: records writes, readback words and protocol rule violations.
  typedef struct packed { logic [63:0] a; logic [63:0] d; } wr_t;
  wr_t         iq[$];
  wr_t         dq[$];
  logic [63:0] oq[$];
  int          en_cycles = 0, bad_hs = 0, bad_arst = 0, bad_hold = 0, ren_seen = 0;
  logic        mon_run_nz;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_out = '0;

  always @(negedge clk) begin
    if (!arst) begin
      if (wen_ext) begin
        iq.push_back('{a: addr_ext, d: {32'b0, wdata_ext}});
        if (!(in_valid && in_ready)) bad_hs <= bad_hs + 1;
      end
      if (wen_ext_2) begin
        dq.push_back('{a: addr_ext_2, d: wdata_ext_2});
        if (!(in_valid && in_ready)) bad_hs <= bad_hs + 1;
      end
      if (ren_ext) ren_seen <= ren_seen + 1;
      if (cpu_enable) en_cycles <= en_cycles + 1;
      if (out_valid && out_ready) oq.push_back(out_data);
      if ((in_ready && cpu_arst_n) || (cpu_enable && !cpu_arst_n) ||
          ((out_valid || done) && mon_run_nz && !cpu_arst_n))
        bad_arst <= bad_arst + 1;
      if (prev_stall && out_data != prev_out) bad_hold <= bad_hold + 1;
      prev_stall <= out_valid && !out_ready;
      prev_out   <= out_data;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_cpu_en"}, cpu_enable, 0);
    check({tag, "_cpu_arst_n"}, cpu_arst_n, 0);
    check({tag, "_wen"}, {wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
    check({tag, "_addr"}, addr_ext, 0);
    check({tag, "_addr2"}, addr_ext_2, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  // Runs one job and compares everything observed against the reference built from the lengths.
  task automatic run_job(input int il, input int dl, input int rc, input int ul,
                         input int vmode, input int rmode, input bit inject,
                         input int abort_hs, output int lat);
    int eil, edl, eul, i0, d0, o0, e0, bh0, ba0, bo0, r0;
    int cyc, limit, popped, hs_total, en_seen, ov_seen, inj, n;
    logic [63:0] all[$];
    logic [63:0] sq[$];
    logic [63:0] w;
    bit hs;
    eil = (il > 512) ? 512 : il;
    edl = (dl > 1024) ? 1024 : dl;
    eul = (ul > 1024) ? 1024 : ul;
    for (int k = 0; k < eil + edl; k++) all.push_back({$urandom, $urandom});
    sq = all;
    i0 = iq.size(); d0 = dq.size(); o0 = oq.size(); e0 = en_cycles;
    bh0 = bad_hs; ba0 = bad_arst; bo0 = bad_hold; r0 = ren_seen;
    limit = 200 + 6 * (eil + edl) + rc + 14 * eul;
    lat = -1;

    @(posedge clk); #1;
    imem_len = 10'(il); dmem_len = 11'(dl); run_cycles = CNT_W'(rc); dump_len = 11'(ul);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mon_run_nz = (rc != 0);
    hs = 0; popped = 0; hs_total = 0; en_seen = 0; ov_seen = 0; inj = 0; cyc = 0;
    while (1) begin
      if (hs) begin
        w = sq.pop_front();
        if (popped >= eil) ref_d[popped - eil] = w;
        popped++;
      end
      in_valid = (sq.size() > 0) && ((vmode == 0) || (vmode == 1 && cyc % 2 == 0) ||
                                     (vmode == 2 && $urandom_range(0, 1) == 1));
      in_data  = (sq.size() > 0) ? sq[0] : {$urandom, $urandom};
      out_ready = (rmode == 0) || (rmode == 1 && ov_seen >= 5) ||
                  (rmode == 2 && $urandom_range(0, 1) == 1);
      start = (inj == 1);
      if (inj == 1) begin
        imem_len = 10'($urandom); dmem_len = 11'($urandom);
        run_cycles = CNT_W'($urandom_range(1, 99)); dump_len = 11'($urandom);
        inj = 2;
      end
      @(negedge clk);
      if (cyc == 0 && (eil + edl) > 0) check("arst_low_after_start", cpu_arst_n, 0);
      hs = in_valid && in_ready;
      if (hs) hs_total++;
      if (cpu_enable) en_seen++;
      if (out_valid) ov_seen++;
      if (inject && inj == 0 && en_seen == 2) inj = 1;
      if (abort_hs > 0 && hs_total == abort_hs) begin
        #2 arst = 1'b1;
        in_valid = 1'b0;
        #1 check_reset("rst_mid");
        @(posedge clk); #1;
        arst = 1'b0;
        check_reset("rst_after");
        return;
      end
      if (done) break;
      cyc++;
      if (cyc > limit) begin
        check("timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    lat = cyc + 1;
    #2;
    in_valid = 1'b0;

    n = iq.size() - i0;
    check("imem_writes", n, eil);
    for (int k = 0; k < eil && k < n; k++) begin
      check("imem_addr", iq[i0 + k].a, 64'(k * 4));
      check("imem_data", iq[i0 + k].d, {32'b0, all[k][31:0]});
    end
    n = dq.size() - d0;
    check("dmem_writes", n, edl);
    for (int k = 0; k < edl && k < n; k++) begin
      check("dmem_addr", dq[d0 + k].a, 64'(k * 8));
      check("dmem_data", dq[d0 + k].d, all[eil + k]);
    end
    check("enable_cycles", en_cycles - e0, rc);
    n = oq.size() - o0;
    check("dump_words", n, eul);
    for (int k = 0; k < eul && k < n; k++) check("dump_data", oq[o0 + k], ref_d[k]);
    check("write_without_handshake", bad_hs - bh0, 0);
    check("cpu_arst_n_sequence", bad_arst - ba0, 0);
    check("out_data_hold", bad_hold - bo0, 0);
    check("imem_read", ren_seen - r0, 0);
    check("done_set", done, 1);
    check("busy_clear", busy, 0);
  endtask

  int lat;

  initial begin
    arst = 1'b1; mem_init = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; imem_len = '0; dmem_len = '0; run_cycles = '0; dump_len = '0;
    mon_run_nz = 1'b0;
    for (int i = 0; i < 1024; i++) ref_d[i] = seed_word(i);
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    check_reset("por");
    arst = 1'b0;
    @(posedge clk); #1;
    check_reset("idle");

    // Abort while the third data doubleword is being handshaken.
    run_job(2, 6, 5, 3, 0, 0, 0, 2 + 3, lat);
    // Dump only: shows which words the aborted job actually committed.
    run_job(0, 0, 0, 4, 0, 0, 0, 0, lat);

    run_job(4, 2, 10, 2, 0, 0, 0, 0, lat);
    run_job(5, 4, 6, 3, 1, 1, 0, 0, lat);
    run_job(0, 0, 3, 0, 2, 2, 0, 0, lat);
    run_job(0, 0, 0, 0, 0, 0, 0, 0, lat);
    check("all_zero_latency", lat, 1);

    run_job(600, 0, 2, 0, 0, 0, 0, 0, lat);
    check("clamp_last_addr", iq[iq.size() - 1].a, 64'd2044);
    run_job(3, 3, 20, 2, 0, 2, 1, 0, lat);

    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 25),
              $urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 0, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
